// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and shared-memory channels of the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: IFU/LSU arbiter onto one memory port, one txn in flight.
// LSU has priority; IFU is forced through after STARVE_LIMIT LSU grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int SW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW0 = $clog2(TIMEOUT + 1);
  localparam int WW  = (TW0 > 8) ? TW0 : 8;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          wen_q, wen_d;
  logic          err_q, err_d;
  logic          own_lsu_q, own_lsu_d;

  logic idle, ifu_win, ifu_acc, lsu_acc, resp;

  assign idle    = ~rst & (state_q == S_IDLE);
  assign ifu_win = bus.ifu_req_valid &
                   (~bus.lsu_req_valid | (starve_q == STARVE_MAX));
  assign ifu_acc = idle & ifu_win;
  assign lsu_acc = idle & bus.lsu_req_valid & ~ifu_win;

  assign bus.ifu_req_ready = ifu_acc;
  assign bus.lsu_req_ready = lsu_acc;

  assign bus.mem_req_valid = ~rst & (state_q == S_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  // reset gating keeps a mid-transaction reset from leaking a response
  assign resp               = ~rst & (state_q == S_RESP);
  assign bus.ifu_resp_valid = resp & ~own_lsu_q;
  assign bus.lsu_resp_valid = resp & own_lsu_q;
  assign bus.ifu_rdata      = rdata_q;
  assign bus.lsu_rdata      = rdata_q;
  assign bus.ifu_resp_err   = err_q;
  assign bus.lsu_resp_err   = err_q;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wmask_d   = wmask_q;
    wen_d     = wen_q;
    err_d     = err_q;
    own_lsu_d = own_lsu_q;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_acc) begin
          state_d   = S_REQ;
          own_lsu_d = 1'b0;
          addr_d    = bus.ifu_addr;
          wen_d     = 1'b0;
          wdata_d   = '0;
          wmask_d   = 4'b0000;
          starve_d  = '0;
        end else if (lsu_acc) begin
          state_d   = S_REQ;
          own_lsu_d = 1'b1;
          addr_d    = bus.lsu_addr;
          wen_d     = bus.lsu_wen;
          wdata_d   = bus.lsu_wdata;
          wmask_d   = bus.lsu_wmask;
          if (bus.ifu_req_valid && starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = S_RESP;
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
        end else if (wcnt_q == WAIT_MAX) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      wcnt_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wmask_q   <= '0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
      own_lsu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wmask_q   <= wmask_d;
      wen_q     <= wen_d;
      err_q     <= err_d;
      own_lsu_q <= own_lsu_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, transaction-level model checked
// every cycle, plus hand-computed literal expectations.
module tb_mem_arbiter;
  localparam int SL = 4;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .STARVE_LIMIT(SL),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // transaction-level model
  bit          live = 0;
  bit          m_busy, m_issued, m_have, m_own;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;
  logic        m_wen, m_err;
  int          m_waited, m_starve;

  bit glog[$];
  int n_ifu_resp, n_lsu_resp;
  bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  function automatic bit exp_ifu_rdy();
    return !rst && !m_busy && bus.ifu_req_valid &&
           (!bus.lsu_req_valid || m_starve == SL);
  endfunction

  function automatic bit exp_lsu_rdy();
    return !rst && !m_busy && bus.lsu_req_valid &&
           !(bus.ifu_req_valid && m_starve == SL);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      live = 1;
      m_busy = 0; m_issued = 0; m_have = 0; m_own = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_wmask = 0;
      m_wen = 0; m_err = 0; m_waited = 0; m_starve = 0;
    end else if (!m_busy) begin
      if (exp_ifu_rdy()) begin
        m_busy = 1; m_own = 0;
        m_addr = bus.ifu_addr; m_wen = 0;
        m_wdata = 0; m_wmask = 0;
        m_starve = 0;
      end else if (exp_lsu_rdy()) begin
        m_busy = 1; m_own = 1;
        m_addr = bus.lsu_addr; m_wen = bus.lsu_wen;
        m_wdata = bus.lsu_wdata; m_wmask = bus.lsu_wmask;
        if (bus.ifu_req_valid && m_starve < SL) m_starve++;
      end
    end else if (!m_issued) begin
      if (bus.mem_req_ready) begin
        m_issued = 1; m_waited = 0;
      end
    end else if (!m_have) begin
      if (bus.mem_resp_valid) begin
        m_have = 1; m_rdata = bus.mem_rdata; m_err = 0;
      end else if (m_waited == TO) begin
        m_have = 1; m_rdata = 0; m_err = 1;
      end else begin
        m_waited++;
      end
    end else begin
      m_busy = 0; m_issued = 0; m_have = 0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("ifu_req_ready", bus.ifu_req_ready, exp_ifu_rdy());
      chk("lsu_req_ready", bus.lsu_req_ready, exp_lsu_rdy());
      chk("mem_req_valid", bus.mem_req_valid,
          !rst && m_busy && !m_issued);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wen", bus.mem_wen, m_wen);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mem_wmask", bus.mem_wmask, m_wmask);
      chk("ifu_resp_valid", bus.ifu_resp_valid,
          !rst && m_have && !m_own);
      chk("lsu_resp_valid", bus.lsu_resp_valid,
          !rst && m_have && m_own);
      if (!rst && m_have && !m_own) begin
        chk("ifu_rdata", bus.ifu_rdata, m_rdata);
        chk("ifu_resp_err", bus.ifu_resp_err, m_err);
      end
      if (!rst && m_have && m_own) begin
        chk("lsu_rdata", bus.lsu_rdata, m_rdata);
        chk("lsu_resp_err", bus.lsu_resp_err, m_err);
      end
      if (bus.ifu_req_valid && bus.ifu_req_ready) glog.push_back(1'b0);
      if (bus.lsu_req_valid && bus.lsu_req_ready) glog.push_back(1'b1);
      if (bus.ifu_resp_valid) n_ifu_resp++;
      if (bus.lsu_resp_valid) n_lsu_resp++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr = 32'h1234_5678;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr = 0; bus.lsu_wen = 0;
    bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
    bus.mem_rdata = 0;
    tick(); tick();
    chk("rst_ifu_ready", bus.ifu_req_ready, 0);
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_ifu_resp_valid", bus.ifu_resp_valid, 0);
    chk("rst_ifu_resp_err", bus.ifu_resp_err, 0);
    chk("rst_ifu_rdata", bus.ifu_rdata, 0);

    // single IFU read, minimum latency
    rst = 1'b0;
    bus.ifu_addr = 32'h8000_0000;
    bus.mem_req_ready = 1;
    tick();
    bus.ifu_req_valid = 0; bus.ifu_addr = 32'hFFFF_FFFF;
    chk("t1_mem_valid", bus.mem_req_valid, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h8000_0000);
    tick();
    bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_0413;
    tick();
    bus.mem_resp_valid = 0; bus.mem_rdata = 0;
    chk("t3_ifu_resp_valid", bus.ifu_resp_valid, 1);
    chk("t3_ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
    chk("t3_ifu_resp_err", bus.ifu_resp_err, 0);
    chk("t3_lsu_resp_valid", bus.lsu_resp_valid, 0);
    tick();
    chk("t4_ifu_resp_gone", bus.ifu_resp_valid, 0);

    // both requesters always valid: anti-starvation order
    glog.delete();
    n_ifu_resp = 0; n_lsu_resp = 0;
    bus.mem_req_ready = 1; bus.mem_resp_valid = 1;
    bus.mem_rdata = 32'h1111_0000;
    bus.ifu_addr = 32'h8000_0010;
    bus.lsu_addr = 32'h8000_2000; bus.lsu_wen = 0;
    bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'hF;
    bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
    for (int i = 0; i < 60 && glog.size() < 10; i++) tick();
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
    chk("starve_grant_count", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      chk($sformatf("starve_grant_%0d", i), glog[i], pat[i]);
    repeat (6) tick();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
    chk("starve_ifu_resps", n_ifu_resp, 2);
    chk("starve_lsu_resps", n_lsu_resp, 8);

    // LSU store with memory back-pressure
    n_ifu_resp = 0; n_lsu_resp = 0;
    bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_1000;
    bus.lsu_wen = 1; bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wmask = 4'b0011;
    tick();
    bus.lsu_req_valid = 0; bus.lsu_addr = 32'h0BAD_0BAD;
    bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'hF; bus.lsu_wen = 0;
    for (int i = 0; i < 5; i++) begin
      chk("st_mem_valid", bus.mem_req_valid, 1);
      chk("st_mem_addr", bus.mem_addr, 32'h8000_1000);
      chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("st_mem_wmask", bus.mem_wmask, 4'b0011);
      chk("st_mem_wen", bus.mem_wen, 1);
      tick();
    end
    bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_1234;
    tick();
    bus.mem_resp_valid = 0;
    chk("st_lsu_resp_valid", bus.lsu_resp_valid, 1);
    chk("st_ifu_resp_valid", bus.ifu_resp_valid, 0);
    tick();
    chk("st_lsu_resp_count", n_lsu_resp, 1);
    chk("st_ifu_resp_count", n_ifu_resp, 0);

    // memory never answers: timeout abort
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0040;
    bus.mem_req_ready = 1;
    tick();
    bus.ifu_req_valid = 0;
    tick();
    bus.mem_req_ready = 0;
    repeat (4) begin
      chk("to_wait_no_resp", bus.ifu_resp_valid, 0);
      tick();
    end
    chk("to_ifu_resp_valid", bus.ifu_resp_valid, 1);
    chk("to_ifu_resp_err", bus.ifu_resp_err, 1);
    chk("to_ifu_rdata", bus.ifu_rdata, 0);
    tick();
    chk("to_idle_no_resp", bus.ifu_resp_valid, 0);
    chk("to_idle_mem_valid", bus.mem_req_valid, 0);

    // spurious responses in IDLE, REQ and RESP
    n_ifu_resp = 0; n_lsu_resp = 0;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'hBAD0_0001;
    tick();
    bus.mem_resp_valid = 0;
    chk("sp_idle_ifu_resp", bus.ifu_resp_valid, 0);
    chk("sp_idle_lsu_resp", bus.lsu_resp_valid, 0);
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0080;
    tick();
    bus.ifu_req_valid = 0;
    bus.mem_req_ready = 1;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'hBAD0_0002;
    tick();
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
    chk("sp_req_ifu_resp", bus.ifu_resp_valid, 0);
    tick();
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'hA5A5_A5A5;
    tick();
    bus.mem_rdata = 32'hBAD0_0003;
    chk("sp_ifu_resp_valid", bus.ifu_resp_valid, 1);
    chk("sp_ifu_rdata", bus.ifu_rdata, 32'hA5A5_A5A5);
    tick();
    bus.mem_resp_valid = 0;
    chk("sp_after_ifu_resp", bus.ifu_resp_valid, 0);
    tick();
    chk("sp_ifu_resp_count", n_ifu_resp, 1);
    chk("sp_lsu_resp_count", n_lsu_resp, 0);

    // reset during WAIT, late response dropped
    n_ifu_resp = 0; n_lsu_resp = 0;
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_00C0;
    bus.mem_req_ready = 1;
    tick();
    bus.ifu_req_valid = 0;
    tick();
    bus.mem_req_ready = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'hBAD0_0004;
    chk("rw_mem_valid", bus.mem_req_valid, 0);
    chk("rw_mem_addr", bus.mem_addr, 0);
    tick();
    bus.mem_resp_valid = 0;
    chk("rw_late_no_resp", bus.ifu_resp_valid, 0);
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0100;
    bus.mem_req_ready = 1;
    tick();
    bus.ifu_req_valid = 0;
    chk("rw_mem_addr2", bus.mem_addr, 32'h8000_0100);
    tick();
    bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_0093;
    tick();
    bus.mem_resp_valid = 0;
    chk("rw_ifu_resp_valid", bus.ifu_resp_valid, 1);
    chk("rw_ifu_rdata", bus.ifu_rdata, 32'h0000_0093);
    tick(); tick();
    chk("rw_ifu_resp_count", n_ifu_resp, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive LSU grants allowed while IFU waits before IFU is forced priority.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT-state cycles before the transaction is aborted with error.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_addr in 32  instruction-fetch request channel (read only).
REQ-006 ifu_resp_valid out 1 / ifu_rdata out 32 / ifu_resp_err out 1  instruction-fetch response.
REQ-007 lsu_req_valid in 1 / lsu_req_ready out 1 / lsu_addr in 32 / lsu_wen in 1 / lsu_wdata in 32 / lsu_wmask in 4  load/store request channel.
REQ-008 lsu_resp_valid out 1 / lsu_rdata out 32 / lsu_resp_err out 1  load/store response; sent for writes too.
REQ-009 mem_req_valid out 1 / mem_req_ready in 1 / mem_addr out 32 / mem_wen out 1 / mem_wdata out 32 / mem_wmask out 4  shared memory request port.
REQ-010 mem_resp_valid in 1 / mem_rdata in 32  shared memory response port.

Function
REQ-011 FSM states IDLE, REQ, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-012 IDLE: grant computed combinationally; only the granted requester sees req_ready=1; the other sees 0.
REQ-013 Grant rule: LSU wins when both are valid, unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
REQ-014 starve_cnt: incremented, saturating at STARVE_LIMIT, on an LSU acceptance while ifu_req_valid=1; cleared on any IFU acceptance; unchanged otherwise.
REQ-015 Acceptance = req_valid & req_ready in IDLE; addr/wen/wdata/wmask and owner ID are latched; next state REQ. Requester inputs are don't-care after acceptance.
REQ-016 IFU acceptance latches wen=0 and wmask=4'b0000.
REQ-017 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go to WAIT and clear the wait counter.
REQ-018 WAIT: on mem_resp_valid=1, latch mem_rdata, set err=0, go to RESP. If the wait counter reaches TIMEOUT first, latch rdata=0 and err=1, go to RESP.
REQ-019 mem_resp_valid is ignored in IDLE, REQ and RESP (spurious responses are dropped); in REQ this holds even when it coincides with mem_req_ready.
REQ-020 RESP: the owner's resp_valid=1 for exactly one cycle, with rdata/resp_err from the latched values; the non-owner's resp_valid=0; next state IDLE.
REQ-021 No new request is accepted in the RESP cycle; earliest next acceptance is the following IDLE cycle.
REQ-022 Minimum latency: accepted at cycle T; mem_req_valid at T+1; with mem_req_ready at T+1 and mem_resp_valid at T+2, resp_valid at T+3.
REQ-023 mem_req_valid=0 outside REQ; mem_addr/wen/wdata/wmask always reflect the latched registers.
REQ-024 The wait counter is 8 bits minimum (width sized to TIMEOUT) and does not wrap; TIMEOUT=0 means abort on the first WAIT cycle without a response.
REQ-025 The block never reorders, duplicates or merges requests; each acceptance yields exactly one response to the same requester.

Reset
REQ-026 While rst=1: state=IDLE, starve_cnt=0, wait counter=0, latched addr/wdata/rdata=0, wen=0, wmask=0, err=0, owner=IFU.
REQ-027 Reset outputs: all req_ready=0, resp_valid=0, resp_err=0, mem_req_valid=0, all data/address outputs 0.
REQ-028 rst asserted mid-transaction (REQ/WAIT/RESP) aborts it with no response; a late mem_resp_valid after reset is ignored per REQ-019.

Verification
REQ-029 Single IFU read, addr 0x80000000, mem ready immediately, rdata 0x00000413 one cycle later -> ifu_resp_valid at T+3, ifu_rdata=0x00000413, err=0.
REQ-030 Both valid every cycle, STARVE_LIMIT=4 -> grant order LSU,LSU,LSU,LSU,IFU, repeating; no IFU starvation.
REQ-031 LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011, mem_req_ready held 0 for 5 cycles -> mem fields stable throughout; single lsu_resp_valid after the response.
REQ-032 No mem_resp_valid, TIMEOUT=3 -> the owner sees resp_valid with err=1 and rdata=0 after 4 WAIT cycles; the FSM returns to IDLE.
REQ-033 mem_resp_valid pulsed in IDLE and in REQ -> no resp_valid to either requester; the real response is still delivered once.
REQ-034 rst asserted for one cycle in WAIT, then the memory responds -> no resp_valid, state IDLE, next IFU request serviced normally.
